// File: rtl/mux_arb_2to1.sv
// Wormhole switch arbiter for a 2:1 flit mux: grants one port per cycle, locks the
// output to a packet from HEAD to TAIL, and tracks downstream credits per VC.
module mux_arb_2to1 #(
  parameter int DATAW = 66,
  parameter int VCHW  = 2,
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ivalid_0,
  input  logic [1:0]      itype_0,
  input  logic [VCHW-1:0] ivch_0,
  input  logic            ivalid_1,
  input  logic [1:0]      itype_1,
  input  logic [VCHW-1:0] ivch_1,
  input  logic            icredit_valid,
  input  logic [VCHW-1:0] icredit_vch,
  output logic [1:0]      sel,
  output logic            ogrant_0,
  output logic            ogrant_1,
  output logic [1:0]      olock,
  output logic            oerr
);

  localparam int NVC = 1 << VCHW;
  localparam int CW  = $clog2(DEPTH + 1);

  localparam logic [1:0] T_NONE = 2'b00;
  localparam logic [1:0] T_HEAD = 2'b01;
  localparam logic [1:0] T_DATA = 2'b10;
  localparam logic [1:0] T_TAIL = 2'b11;

  // Only the two type bits of the flit reach this block; the flit must hold them.
  if (DATAW < 3) begin : g_bad_dataw
    $error("mux_arb_2to1: DATAW must leave room for the type field");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    LOCK0 = 2'b01,
    LOCK1 = 2'b10
  } state_t;

  state_t          state;
  logic            last;
  logic [VCHW-1:0] lock_vch;
  logic [CW-1:0]   credit [NVC];
  logic            err;

  logic [1:0]      elig;
  logic [1:0]      perr;
  logic [1:0]      gnt;
  logic [VCHW-1:0] gvch;
  logic [NVC-1:0]  dec_v;
  logic [NVC-1:0]  inc_v;

  always_comb begin
    elig = 2'b00;
    perr = 2'b00;
    gnt  = 2'b00;
    case (state)
      IDLE: begin
        elig[0] = ivalid_0 && (itype_0 == T_HEAD) && (credit[ivch_0] != '0);
        elig[1] = ivalid_1 && (itype_1 == T_HEAD) && (credit[ivch_1] != '0);
        perr[0] = ivalid_0 && ((itype_0 == T_DATA) || (itype_0 == T_TAIL));
        perr[1] = ivalid_1 && ((itype_1 == T_DATA) || (itype_1 == T_TAIL));
        // Contention goes to the port that did not finish the previous packet.
        if (elig == 2'b11) gnt = last ? 2'b01 : 2'b10;
        else               gnt = elig;
      end
      LOCK0: begin
        perr[0] = ivalid_0 && ((itype_0 == T_HEAD) || (itype_0 == T_NONE));
        elig[0] = ivalid_0 && !perr[0] && (credit[lock_vch] != '0);
        gnt     = {1'b0, elig[0]};
      end
      LOCK1: begin
        perr[1] = ivalid_1 && ((itype_1 == T_HEAD) || (itype_1 == T_NONE));
        elig[1] = ivalid_1 && !perr[1] && (credit[lock_vch] != '0);
        gnt     = {elig[1], 1'b0};
      end
      default: begin
        gnt = 2'b00;
      end
    endcase

    if (state == IDLE) gvch = gnt[1] ? ivch_1 : ivch_0;
    else               gvch = lock_vch;

    for (int v = 0; v < NVC; v++) begin
      dec_v[v] = (gnt != 2'b00) && (gvch == VCHW'(v));
      inc_v[v] = icredit_valid && (icredit_vch == VCHW'(v));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      last     <= 1'b1;
      lock_vch <= '0;
      err      <= 1'b0;
      for (int v = 0; v < NVC; v++) credit[v] <= CW'(DEPTH);
    end else begin
      case (state)
        IDLE: begin
          if (gnt[0]) begin
            state    <= LOCK0;
            lock_vch <= ivch_0;
          end else if (gnt[1]) begin
            state    <= LOCK1;
            lock_vch <= ivch_1;
          end
        end
        LOCK0: begin
          if (gnt[0] && (itype_0 == T_TAIL)) begin
            state <= IDLE;
            last  <= 1'b0;
          end
        end
        LOCK1: begin
          if (gnt[1] && (itype_1 == T_TAIL)) begin
            state <= IDLE;
            last  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase

      // A return and a consume on the same VC cancel out.
      for (int v = 0; v < NVC; v++) begin
        if (dec_v[v] && !inc_v[v]) begin
          credit[v] <= credit[v] - CW'(1);
        end else if (inc_v[v] && !dec_v[v]) begin
          if (credit[v] == CW'(DEPTH)) err <= 1'b1;
          else                         credit[v] <= credit[v] + CW'(1);
        end
      end

      if (perr != 2'b00) err <= 1'b1;
    end
  end

  assign sel      = gnt;
  assign ogrant_0 = gnt[0];
  assign ogrant_1 = gnt[1];
  assign olock    = {state == LOCK1, state == LOCK0};
  assign oerr     = err;

endmodule

// File: tb/tb_mux_arb_2to1.sv
// Directed bench for mux_arb_2to1: packet locking, credit stalls and returns,
// round-robin contention, protocol errors and mid-packet reset.
module tb_mux_arb_2to1;

  localparam logic [1:0] NONE = 2'b00;
  localparam logic [1:0] HEAD = 2'b01;
  localparam logic [1:0] DATA = 2'b10;
  localparam logic [1:0] TAIL = 2'b11;

  logic       clk = 1'b0;
  logic       rst;
  logic       ivalid_0, ivalid_1;
  logic [1:0] itype_0, itype_1;
  logic [1:0] ivch_0, ivch_1;
  logic       icredit_valid;
  logic [1:0] icredit_vch;
  logic [1:0] sel;
  logic       ogrant_0, ogrant_1;
  logic [1:0] olock;
  logic       oerr;

  int total = 0;
  int fails = 0;

  mux_arb_2to1 #(.DATAW(66), .VCHW(2), .DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .ivalid_0(ivalid_0), .itype_0(itype_0), .ivch_0(ivch_0),
    .ivalid_1(ivalid_1), .itype_1(itype_1), .ivch_1(ivch_1),
    .icredit_valid(icredit_valid), .icredit_vch(icredit_vch),
    .sel(sel), .ogrant_0(ogrant_0), .ogrant_1(ogrant_1),
    .olock(olock), .oerr(oerr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Apply one cycle of inputs, then let combinational outputs settle.
  task automatic drv(input logic v0, input logic [1:0] t0, input logic [1:0] c0,
                     input logic v1, input logic [1:0] t1, input logic [1:0] c1,
                     input logic cv, input logic [1:0] cc);
    ivalid_0 = v0; itype_0 = t0; ivch_0 = c0;
    ivalid_1 = v1; itype_1 = t1; ivch_1 = c1;
    icredit_valid = cv; icredit_vch = cc;
    #2;
  endtask

  function automatic logic [1:0] ty(input int k);
    return (k == 0) ? HEAD : ((k == 21) ? TAIL : DATA);
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    drv(0, NONE, 0, 0, NONE, 0, 0, 0);
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int k;
    logic exp_g;

    do_reset();
    chk("rst_sel", sel, 2'b00);
    chk("rst_grant", {ogrant_1, ogrant_0}, 2'b00);
    chk("rst_lock", olock, 2'b00);
    chk("rst_err", {1'b0, oerr}, 2'b00);

    // Port 1 packet with no credit returns: four grants then stall holding the lock.
    k = 0;
    for (int c = 0; c < 8; c++) begin
      drv(0, NONE, 0, 1, ty(k), 0, 0, 0);
      chk("s1_sel", sel, (c < 4) ? 2'b10 : 2'b00);
      if (c >= 4) chk("s1_lock", olock, 2'b10);
      if (c < 4) k++;
      tick();
    end

    // One credit per cycle: each return enables a grant the following cycle.
    for (int c = 0; c < 22; c++) begin
      exp_g = (c >= 1) && (c <= 18);
      drv(0, NONE, 0, (k <= 21), ty(k), 0, 1, 0);
      chk("s2_sel", sel, exp_g ? 2'b10 : 2'b00);
      chk("s2_grant1", {1'b0, ogrant_1}, {1'b0, exp_g});
      chk("s2_lock", olock, (c <= 18) ? 2'b10 : 2'b00);
      if (exp_g) k++;
      tick();
    end
    drv(0, NONE, 0, 0, NONE, 0, 0, 0);
    chk("s2_err", {1'b0, oerr}, 2'b00);
    tick();

    // Contention: port 0 wins first, port 1 waits for the whole 22-flit packet.
    for (int c = 0; c < 22; c++) begin
      drv(1, ty(c), 0, 1, HEAD, 1, 1, 0);
      chk("s3_sel0", sel, 2'b01);
      chk("s3_lock0", olock, (c == 0) ? 2'b00 : 2'b01);
      tick();
    end
    drv(0, NONE, 0, 1, HEAD, 1, 1, 1);
    chk("s3_p1_head", sel, 2'b10);
    tick();
    drv(0, NONE, 0, 1, DATA, 1, 1, 1);
    chk("s3_p1_data", sel, 2'b10);
    tick();
    drv(0, NONE, 0, 1, TAIL, 1, 1, 1);
    chk("s3_p1_tail", sel, 2'b10);
    tick();
    drv(1, HEAD, 0, 1, HEAD, 1, 1, 0);
    chk("s3_rr_head", sel, 2'b01);
    tick();
    drv(1, TAIL, 0, 1, HEAD, 1, 1, 0);
    chk("s3_rr_tail", sel, 2'b01);
    tick();
    drv(0, NONE, 0, 1, HEAD, 1, 1, 1);
    chk("s3_p1_head2", sel, 2'b10);
    tick();
    drv(0, NONE, 0, 1, TAIL, 1, 1, 1);
    chk("s3_p1_tail2", sel, 2'b10);
    tick();
    drv(0, NONE, 0, 0, NONE, 0, 0, 0);
    chk("s3_idle_lock", olock, 2'b00);
    chk("s3_err", {1'b0, oerr}, 2'b00);
    tick();

    // Simultaneous grant and return at credit 2 leaves credit at 2.
    drv(1, HEAD, 0, 0, NONE, 0, 0, 0); chk("s4_h", sel, 2'b01); tick();
    drv(1, DATA, 0, 0, NONE, 0, 0, 0); chk("s4_d1", sel, 2'b01); tick();
    drv(1, DATA, 0, 0, NONE, 0, 1, 0); chk("s4_d2_ret", sel, 2'b01); tick();
    drv(1, DATA, 0, 0, NONE, 0, 0, 0); chk("s4_d3", sel, 2'b01); tick();
    drv(1, DATA, 0, 0, NONE, 0, 0, 0); chk("s4_d4", sel, 2'b01); tick();
    drv(1, DATA, 0, 0, NONE, 0, 0, 0);
    chk("s4_stall", sel, 2'b00);
    chk("s4_stall_lock", olock, 2'b01);
    tick();
    for (int c = 0; c < 4; c++) begin
      drv(0, NONE, 0, 0, NONE, 0, 1, 0);
      chk("s4_wait", sel, 2'b00);
      tick();
    end
    drv(1, TAIL, 0, 0, NONE, 0, 1, 0);
    chk("s4_tail", sel, 2'b01);
    tick();
    // Credit is back at DEPTH: one more return overflows.
    drv(0, NONE, 0, 0, NONE, 0, 1, 0);
    chk("s4_pre_err", {1'b0, oerr}, 2'b00);
    chk("s4_idle_lock", olock, 2'b00);
    tick();
    for (int c = 0; c < 3; c++) begin
      drv(0, NONE, 0, 0, NONE, 0, 0, 0);
      chk("s4_err_sticky", {1'b0, oerr}, 2'b01);
      tick();
    end

    // DATA while idle is a protocol error; a following HEAD is still served.
    do_reset();
    drv(0, NONE, 0, 0, NONE, 0, 0, 0);
    chk("s5_err_clr", {1'b0, oerr}, 2'b00);
    tick();
    drv(1, DATA, 0, 0, NONE, 0, 0, 0);
    chk("s5_data_sel", sel, 2'b00);
    tick();
    drv(0, NONE, 0, 1, HEAD, 2, 0, 0);
    chk("s5_err_set", {1'b0, oerr}, 2'b01);
    chk("s5_p1_head", sel, 2'b10);
    tick();
    drv(0, NONE, 0, 1, TAIL, 2, 0, 0);
    chk("s5_p1_tail", sel, 2'b10);
    tick();

    // Reset mid-packet while LOCK1 with credit[0]=1.
    do_reset();
    drv(0, NONE, 0, 1, HEAD, 0, 0, 0); chk("s6_h", sel, 2'b10); tick();
    drv(0, NONE, 0, 1, DATA, 0, 0, 0); chk("s6_d1", sel, 2'b10); tick();
    drv(0, NONE, 0, 1, DATA, 0, 0, 0); chk("s6_d2", sel, 2'b10); tick();
    rst = 1'b1;
    drv(0, NONE, 0, 1, DATA, 0, 0, 0);
    tick();
    rst = 1'b0;
    drv(0, NONE, 0, 0, NONE, 0, 0, 0);
    chk("s6_sel_idle", sel, 2'b00);
    chk("s6_lock_idle", olock, 2'b00);
    tick();
    for (int c = 0; c < 5; c++) begin
      drv(1, (c == 0) ? HEAD : DATA, 0, 0, NONE, 0, 0, 0);
      chk("s6_p0", sel, (c < 4) ? 2'b01 : 2'b00);
      tick();
    end

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mux_arb_2to1.md
# mux_arb_2to1

Wormhole switch arbiter that drives the select of the 2:1 flit mux and keeps per-VC downstream credit counters. It sits directly upstream of the mux in the router output path: it inspects the valid, type and VC of both input ports and grants one port per cycle. Once a head flit wins, it locks the output to that port until the matching tail flit passes. It only forwards a flit when the downstream buffer for that VC has a free slot.

## Interface
- DATAW, 66: flit width; type field is bits [DATAW-1:DATAW-2] (the arbiter receives only these).
- VCHW, 2: VC id width; NVC = 2**VCHW.
- DEPTH, 4: downstream buffer slots per VC (credit reset value).
- Type encoding (fixed): 2'b00 NONE, 2'b01 HEAD, 2'b10 DATA, 2'b11 TAIL.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous reset, active-high.
- ivalid_0  in  1  port 0 flit valid.
- itype_0  in  2  port 0 flit type (idata_0[DATAW-1:DATAW-2]).
- ivch_0  in  VCHW  port 0 flit VC.
- ivalid_1, itype_1, ivch_1  in  1/2/VCHW  same for port 1.
- icredit_valid  in  1  downstream freed one slot this cycle.
- icredit_vch  in  VCHW  VC of the returned credit.
- sel  out  2  one-hot mux select: 2'b01 port 0, 2'b10 port 1, 2'b00 none.
- ogrant_0  out  1  port 0 flit consumed this cycle (input buffer pops).
- ogrant_1  out  1  port 1 flit consumed this cycle.
- olock  out  2  one-hot current packet owner; 2'b00 when idle.
- oerr  out  1  sticky protocol error flag; cleared only by rst.

## Operation
- State: IDLE, LOCK0, LOCK1. Registers: state, lock_vch, last (last port to complete a packet), credit[NVC] each $clog2(DEPTH+1) bits, err.
- Eligibility is `elig_i`. It is:
  - in IDLE: ivalid_i & itype_i==HEAD & credit[ivch_i]!=0;
  - in LOCKi: ivalid_i & credit[lock_vch]!=0.
  - The non-owner port is never eligible in LOCKi.
- Grant in IDLE:
  - Only one eligible: grant it.
  - Both eligible: grant the port != last (round-robin).
- Grant in LOCKi: grant port i when elig_i.
- sel, ogrant_i and olock are combinational from registered state and current inputs. sel is one-hot of the granted port. ogrant_i == sel[i].
- On a HEAD grant in IDLE from port i: state <= LOCKi, lock_vch <= ivch_i.
- On a TAIL grant in LOCKi: state <= IDLE, last <= i.
- HEAD/DATA grant in LOCKi: stay.
- Credit update per VC v, every cycle:
  - dec = grant & (granted flit VC == v), where granted VC is ivch in IDLE and lock_vch in LOCK.
  - inc = icredit_valid & icredit_vch == v.
  - credit <= credit - dec + inc. Both true: unchanged.
  - inc at credit==DEPTH with no dec: saturate at DEPTH, set err.
- Protocol errors (set err; no grant, no state change):
  - In IDLE: valid non-HEAD, non-NONE flit on a port.
  - In LOCKi: valid HEAD or NONE flit from owner i.
- Valid flits of type NONE in IDLE are ignored silently.

## Timing
- Reset values:
  - state IDLE, last 1 (port 0 wins the first contention), lock_vch 0;
  - every credit DEPTH, err 0;
  - outputs sel 2'b00, ogrant_0/1 0, olock 2'b00, oerr 0.
- Latency: zero-cycle grant. An eligible flit is granted in the same cycle it is presented; state and credits update at the next edge.
- Throughput: one flit per cycle while credits last.
- Packet turnaround: the tail grant cycle ends the lock. The next head, from either port, can be granted in the immediately following cycle.
- Credit stall: credit[lock_vch]==0 gives sel 2'b00 and no grant. Lock is held. A credit return in cycle t allows a grant in cycle t+1 (credit is registered).
- Owner ivalid low mid-packet: no grant, lock held indefinitely. The other port is starved until the tail.
- rst mid-packet: next cycle IDLE, credits DEPTH, lock dropped. Upstream/downstream must be reset together.

## Test plan
- Reset, then port 1 sends HEAD(vch 0), 20 DATA, TAIL back-to-back; no credit return, DEPTH=4 → sel=2'b10 for exactly 4 cycles. Then sel=2'b00 with olock=2'b10. credit[0]=0.
- Same as above, then one icredit_valid(vch 0) per cycle → one grant per cycle starting one cycle after each return. After the TAIL grant, olock=2'b00 next cycle. credit[0] ends at 4 once all 22 credits are returned.
- Both ports present HEAD (vch 0 and vch 1) in the same cycle after reset → port 0 granted first and port 1 held for all 22 flits. Port 1 head granted the cycle after port 0's TAIL. Next contention → port 0 wins again (last=1).
- Grant and icredit_valid on the same VC in the same cycle with credit=2 → credit stays 2. icredit_valid with credit=4 and no grant → credit stays 4, oerr=1 and remains 1 until rst.
- Port 0 presents a DATA flit while IDLE → no grant, oerr=1. HEAD from port 1 the next cycle → still granted normally.
- rst asserted mid-packet while LOCK1 with credit[0]=1 → next cycle sel=2'b00, olock=2'b00, all credits 4. Port 0 HEAD presented afterwards → granted immediately.
